lsu_stage: RTL and testbench
============================

# lsu_stage

Parametrised load/store stage for the RV32I pipeline. It sits between EX and WB and owns the byte-banked data memory. It generalises the fixed 32 KiB memory stage in three ways: configurable memory depth and base address, a configurable number of memory wait states with a stall request, and precise misaligned and access-fault exception reporting.

## Interface
Parameters:
- DEPTH_WORDS, 8192: number of 32-bit words in the data memory. Power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be 4-byte aligned.
- WAIT_STATES, 0: extra cycles per memory access. Range 0..7.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset. Synchronous and active-low.
- stall_i, in, 1: pipeline stall from all sources other than this block.
- flush_i, in, 1: kill all in-flight state.
- alu_result_i, in, 32: byte address, or pass-through ALU result.
- store_data_i, in, 32: store data.
- memread_i, in, 1: load request.
- memwrite_i, in, 1: store request.
- width_select_i, in, 3: funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- regwrite_i, in, 1: register write enable.
- rd_addr_i, in, 5: destination register.
- wb_sel_i, in, 2: writeback source select (00 ALU, 01 MEM, 10 PC+4).
- pc_address_i, in, 32: instruction PC.
- ex_valid_i, in, 1: EX slot is valid.
- mem_stall_o, out, 1: this block requests a pipeline hold (combinational).
- mem_data_o, out, 32: extended load data.
- alu_result_o, out, 32: registered ALU result.
- regwrite_o, out, 1: registered register write enable.
- rd_addr_o, out, 5: registered destination register.
- wb_sel_o, out, 2: registered writeback source select.
- pc_address_o, out, 32: registered PC.
- mem_valid_o, out, 1: WB slot is valid.
- exc_valid_o, out, 1: WB slot carries an exception.
- exc_cause_o, out, 4: mcause code (4, 5, 6 or 7).
- exc_tval_o, out, 32: faulting byte address.

## Operation
- Memory op: ex_valid_i & (memread_i | memwrite_i).
- Fault checks (only evaluated for memory ops):
  - misaligned: half-word access with addr[0] set, or word access with addr[1:0] != 0.
  - out of range: addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS.
  - Misaligned takes priority over out of range.
  - Causes: load misaligned 4, load access 5, store misaligned 6, store access 7.
- A faulting op:
  - performs no RAM access and consumes no wait states;
  - reaches WB with regwrite_o=0, exc_valid_o=1 and exc_tval_o = address.
- Word index is (addr - BASE_ADDR)[2 +: log2(DEPTH_WORDS)].
- Memory is four byte banks with synchronous read, 1-cycle latency.
- Byte write enables and lane steering:
  - SB writes lane addr[1:0].
  - SH writes lanes {1,0} or {3,2} by addr[1].
  - SW writes all four lanes.
- Wait-state FSM:
  - IDLE: a non-faulting op with WAIT_STATES>0 moves to WAIT and loads cnt = 0.
  - WAIT: cnt increments each cycle. When cnt == WAIT_STATES-1 the FSM moves to FIRE.
  - FIRE: RAM enable pulses for one cycle, gated by !stall_i. Then IDLE.
  - With WAIT_STATES=0 the FSM is always in FIRE whenever a non-faulting op is present.
- mem_stall_o = non-faulting op present & state != FIRE.
- Internal hold = stall_i | mem_stall_o. Both the sub-register and the MEM/WB register hold while it is high.
- The sub-register captures addr[1:0] and width_select_i. Load extraction uses these registered copies, never the live inputs.
- Loads: LB and LH sign-extend; LBU and LHU zero-extend; any other funct3 gives 0.
- The RAM output holds its value across a stall because no new enable is issued.

## Timing
- Reset (rst_ni=0 at a clock edge): every output register goes to 0, the FSM goes to IDLE, cnt to 0, and mem_stall_o to 0.
- Flush: the sub-register and MEM/WB register clear to 0 and the FSM returns to IDLE. No RAM enable is issued in that cycle, so any pending store is dropped.
- Latency, 0 wait states: an op accepted at edge N appears at the WB outputs after edge N+2.
- Latency, W wait states: the op appears after edge N+2+W, and mem_stall_o is high for exactly W cycles.
- Store then load to the same address on back-to-back cycles: the load returns the new data (read-after-write across cycles).
- Non-memory ops never assert mem_stall_o.
- stall_i asserted during WAIT: cnt keeps counting. The FIRE state waits until stall_i is low.

## Configuration
- LSU_MISALIGN_TRAP_EN:
  - Defined: misaligned accesses fault as described above.
  - Undefined: misaligned accesses are forced aligned (addr[0] cleared for halves, addr[1:0] cleared for words), complete normally, and never raise causes 4 or 6. Access faults remain active.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 -> mem_data_o=0xDEADBEEF at edge N+2; then LB 0x13 -> 0xFFFFFFDE; then LBU 0x13 -> 0x000000DE.
- SH 0x8001 to 0x22, then LH 0x22 -> 0xFFFF8001 and LHU 0x22 -> 0x00008001; bytes 0x20-0x21 are unchanged.
- With LSU_MISALIGN_TRAP_EN defined, LW at 0x6 -> exc_valid_o=1, exc_cause_o=4, exc_tval_o=0x6, regwrite_o=0, no RAM write.
- With DEPTH_WORDS=16, SW to 0x40 -> exc_cause_o=7 and memory is unchanged.
- With WAIT_STATES=2, LW -> mem_stall_o high for exactly 2 cycles and data at edge N+4. flush_i during the wait -> FSM IDLE, no write.
- rst_ni low mid-WAIT -> all outputs 0 at the next edge and FSM IDLE.

Source files
------------

// File: rtl/lsu_stage.sv
// RV32I load/store stage: byte-banked data RAM, wait-state FSM and precise exception reporting.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise they are forced aligned.
module lsu_stage #(
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [2:0]  width_select_i,
  input  logic        regwrite_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [31:0] pc_address_i,
  input  logic        ex_valid_i,
  output logic        mem_stall_o,
  output logic [31:0] mem_data_o,
  output logic [31:0] alu_result_o,
  output logic        regwrite_o,
  output logic [4:0]  rd_addr_o,
  output logic [1:0]  wb_sel_o,
  output logic [31:0] pc_address_o,
  output logic        mem_valid_o,
  output logic        exc_valid_o,
  output logic [3:0]  exc_cause_o,
  output logic [31:0] exc_tval_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LimitAddr = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
  localparam logic [2:0]  LastCnt   = 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StFire} state_e;

  logic        mem_op, is_half, is_word, misaligned, out_of_range, fault, ok_op;
  logic [31:0] eff_addr;
  logic [3:0]  cause;

  always_comb begin
    mem_op  = ex_valid_i & (memread_i | memwrite_i);
    is_half = (width_select_i[1:0] == 2'b01);
    is_word = (width_select_i[1:0] == 2'b10);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (is_half & alu_result_i[0]) | (is_word & |alu_result_i[1:0]);
    eff_addr   = alu_result_i;
`else
    misaligned = 1'b0;
    eff_addr   = {alu_result_i[31:2], alu_result_i[1] & ~is_word,
                  alu_result_i[0] & ~(is_half | is_word)};
`endif
    out_of_range = (eff_addr < BASE_ADDR) || ({1'b0, eff_addr} >= LimitAddr);
    fault        = mem_op & (misaligned | out_of_range);
    ok_op        = mem_op & ~fault;
    if (memwrite_i) cause = misaligned ? 4'd6 : 4'd7;
    else            cause = misaligned ? 4'd4 : 4'd5;
  end

  // Wait-state sequencer; the entry cycle counts as the first wait cycle.
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       fire, hold, ram_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (WAIT_STATES == 0) begin
      fire    = ok_op;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (ok_op) begin
          cnt_d   = 3'd0;
          state_d = (cnt_d == LastCnt) ? StFire : StWait;
        end
        StWait: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_d == LastCnt) state_d = StFire;
        end
        StFire: begin
          fire = ok_op;
          if (!stall_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
    end
  end

  assign mem_stall_o = ok_op & (WAIT_STATES != 0) & (state_q != StFire);
  assign hold        = stall_i | mem_stall_o;
  assign ram_en      = fire & ~stall_i & ~flush_i;

  // Store lane steering
  logic [3:0]    be, we;
  logic [31:0]   wdata;
  logic [AW-1:0] word_idx;

  always_comb begin
    be    = 4'b0000;
    wdata = store_data_i;
    unique case (width_select_i[1:0])
      2'b00: begin
        be    = 4'b0001 << eff_addr[1:0];
        wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be    = eff_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data_i[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    we       = be & {4{ram_en & memwrite_i}};
    word_idx = AW'((eff_addr - BASE_ADDR) >> 2);
  end

  logic [3:0][7:0] mem [DEPTH_WORDS];
  logic [31:0]     rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[word_idx][b] <= wdata[8*b +: 8];
    end
  end

  assign rdata_d = (ram_en & memread_i) ? mem[word_idx] : rdata_q;

  // MEM/WB register and the load-extraction sub-register
  logic [31:0] alu_q, alu_d, pc_q, pc_d, tval_q, tval_d;
  logic        rw_q, rw_d, valid_q, valid_d, exc_q, exc_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  wb_q, wb_d, sub_addr_q, sub_addr_d;
  logic [3:0]  cause_q, cause_d;
  logic [2:0]  sub_width_q, sub_width_d;

  always_comb begin
    {alu_d, pc_d, tval_d, rw_d, valid_d, exc_d} = {alu_q, pc_q, tval_q, rw_q, valid_q, exc_q};
    {rd_d, wb_d, cause_d, sub_addr_d, sub_width_d} =
        {rd_q, wb_q, cause_q, sub_addr_q, sub_width_q};
    if (flush_i) begin
      {alu_d, pc_d, tval_d, rw_d, valid_d, exc_d} = '0;
      {rd_d, wb_d, cause_d, sub_addr_d, sub_width_d} = '0;
    end else if (!hold) begin
      alu_d       = alu_result_i;
      pc_d        = pc_address_i;
      rw_d        = regwrite_i & ex_valid_i & ~fault;
      valid_d     = ex_valid_i;
      exc_d       = fault;
      tval_d      = fault ? alu_result_i : 32'h0;
      cause_d     = fault ? cause : 4'd0;
      rd_d        = rd_addr_i;
      wb_d        = wb_sel_i;
      sub_addr_d  = eff_addr[1:0];
      sub_width_d = width_select_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      rdata_q <= 32'h0;
      {alu_q, pc_q, tval_q, rw_q, valid_q, exc_q} <= '0;
      {rd_q, wb_q, cause_q, sub_addr_q, sub_width_q} <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      {alu_q, pc_q, tval_q, rw_q, valid_q, exc_q} <= {alu_d, pc_d, tval_d, rw_d, valid_d, exc_d};
      {rd_q, wb_q, cause_q, sub_addr_q, sub_width_q} <=
          {rd_d, wb_d, cause_d, sub_addr_d, sub_width_d};
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rdata_q[{sub_addr_q, 3'b000} +: 8];
    ld_half = sub_addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    unique case (sub_width_q)
      3'b000:  mem_data_o = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  mem_data_o = {{16{ld_half[15]}}, ld_half};
      3'b010:  mem_data_o = rdata_q;
      3'b100:  mem_data_o = {24'h0, ld_byte};
      3'b101:  mem_data_o = {16'h0, ld_half};
      default: mem_data_o = 32'h0;
    endcase
  end

  assign alu_result_o = alu_q;
  assign regwrite_o   = rw_q;
  assign rd_addr_o    = rd_q;
  assign wb_sel_o     = wb_q;
  assign pc_address_o = pc_q;
  assign mem_valid_o  = valid_q;
  assign exc_valid_o  = exc_q;
  assign exc_cause_o  = cause_q;
  assign exc_tval_o   = tval_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: 16-word memory at address 0 with two wait states.
module tb_lsu_stage;

  localparam int WS = 2;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk_i = 1'b0, rst_ni = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [31:0] alu_result_i = '0, store_data_i = '0, pc_address_i = '0;
  logic        memread_i = 1'b0, memwrite_i = 1'b0, regwrite_i = 1'b0, ex_valid_i = 1'b0;
  logic [2:0]  width_select_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic [1:0]  wb_sel_i = '0;
  logic        mem_stall_o, regwrite_o, mem_valid_o, exc_valid_o;
  logic [31:0] mem_data_o, alu_result_o, pc_address_o, exc_tval_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  wb_sel_o;
  logic [3:0]  exc_cause_o;

  lsu_stage #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_STATES(WS)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .flush_i(flush_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .memread_i(memread_i),
    .memwrite_i(memwrite_i), .width_select_i(width_select_i), .regwrite_i(regwrite_i),
    .rd_addr_i(rd_addr_i), .wb_sel_i(wb_sel_i), .pc_address_i(pc_address_i),
    .ex_valid_i(ex_valid_i), .mem_stall_o(mem_stall_o), .mem_data_o(mem_data_o),
    .alu_result_o(alu_result_o), .regwrite_o(regwrite_o), .rd_addr_o(rd_addr_o),
    .wb_sel_o(wb_sel_o), .pc_address_o(pc_address_o), .mem_valid_o(mem_valid_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] alu, pc, tval, data;
    logic        rw, exc, chk_data;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [3:0]  cause;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0, n_err = 0;
  logic [31:0] pc_cnt = 32'h100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    ex_valid_i = 0; memread_i = 0; memwrite_i = 0; regwrite_i = 0; stall_i = 0;
  endtask

  // Drive one op, push its expected WB image, hold it until the stage accepts it.
  task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] w,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic rw,
                       input logic [1:0] wb, input logic [3:0] cause, input logic [31:0] data,
                       input int ext, input int exp_stalls);
    exp_t e;
    int   stalls;
    logic acc;
    e.alu = addr; e.pc = pc_cnt; e.rw = rw && cause == 0; e.rd = 5'(pc_cnt >> 2);
    e.wb = wb; e.exc = cause != 0; e.cause = cause; e.tval = (cause != 0) ? addr : 32'h0;
    e.chk_data = rd_en && cause == 0; e.data = data;
    sb_q.push_back(e);
    ex_valid_i = 1; memread_i = rd_en; memwrite_i = wr_en; width_select_i = w;
    alu_result_i = addr; store_data_i = sdata; regwrite_i = rw; rd_addr_i = 5'(pc_cnt >> 2);
    wb_sel_i = wb; pc_address_i = pc_cnt;
    stalls = 0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      stall_i = (i < ext);
      @(negedge clk_i);
      if (mem_stall_o) stalls++;
      acc = !mem_stall_o && !stall_i;
      @(posedge clk_i);
      #1;
      if (acc) break;
    end
    chk("accepted", acc, 1);
    chk("stall_cycles", stalls, exp_stalls);
    pc_cnt += 4;
    idle();
  endtask

  task automatic ld(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] cause, input int ext);
    issue(1, 0, w, a, 32'h0, 1, 2'b01, cause, d, ext, (cause == 0) ? WS : 0);
  endtask

  task automatic st(input logic [2:0] w, input logic [31:0] a, input logic [31:0] sd,
                    input logic [3:0] cause);
    issue(0, 1, w, a, sd, 0, 2'b00, cause, 32'h0, 0, (cause == 0) ? WS : 0);
  endtask

  // Monitor: compares WB outputs after every edge that captured a new slot.
  logic cap_pending = 0;
  initial begin
    forever begin
      @(negedge clk_i);
      if (cap_pending && mem_valid_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_wb", mem_valid_o, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("alu_result", alu_result_o, e.alu);
          chk("pc", pc_address_o, e.pc);
          chk("regwrite", regwrite_o, e.rw);
          chk("rd_addr", rd_addr_o, e.rd);
          chk("wb_sel", wb_sel_o, e.wb);
          chk("exc_valid", exc_valid_o, e.exc);
          chk("exc_cause", exc_cause_o, e.cause);
          chk("exc_tval", exc_tval_o, e.tval);
          if (e.chk_data) chk("mem_data", mem_data_o, e.data);
        end
      end
      cap_pending = rst_ni && !flush_i && !stall_i && !mem_stall_o;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, mem_valid_o, 0);
    chk({tag, "_data"}, mem_data_o, 0);
    chk({tag, "_alu"}, alu_result_o, 0);
    chk({tag, "_rw"}, regwrite_o, 0);
    chk({tag, "_exc"}, {exc_valid_o, exc_cause_o}, 0);
    chk({tag, "_pc"}, pc_address_o, 0);
    chk({tag, "_stall"}, mem_stall_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    @(negedge clk_i);
    chk_all_zero("reset");
    @(posedge clk_i);
    #1;

    st(SW, 32'h00, 32'h0102_0304, 0);
    st(SW, 32'h10, 32'hDEAD_BEEF, 0);
    ld(LW, 32'h10, 32'hDEAD_BEEF, 0, 0);
    ld(LB, 32'h13, 32'hFFFF_FFDE, 0, 0);
    ld(LBU, 32'h13, 32'h0000_00DE, 0, 0);
    ld(LBU, 32'h10, 32'h0000_00EF, 0, 0);
    st(SW, 32'h20, 32'h1122_3344, 0);
    st(SH, 32'h22, 32'h0000_8001, 0);
    ld(LH, 32'h22, 32'hFFFF_8001, 0, 0);
    ld(LHU, 32'h22, 32'h0000_8001, 0, 0);
    ld(LW, 32'h20, 32'h8001_3344, 0, 0);
    st(SB, 32'h21, 32'h0000_0077, 0);
    ld(LW, 32'h20, 32'h8001_7744, 0, 0);
    st(SW, 32'h04, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    ld(LW, 32'h06, 32'h0, 4'd4, 0);
    st(SW, 32'h06, 32'h5566_7788, 4'd6);
    ld(LW, 32'h04, 32'hCAFE_F00D, 0, 0);
    ld(LH, 32'h21, 32'h0, 4'd4, 0);
`else
    ld(LW, 32'h06, 32'hCAFE_F00D, 0, 0);
    st(SW, 32'h06, 32'h5566_7788, 0);
    ld(LW, 32'h04, 32'h5566_7788, 0, 0);
    ld(LH, 32'h21, 32'h0000_7744, 0, 0);
`endif
    issue(0, 0, LW, 32'h1234_5678, 32'h0, 1, 2'b00, 0, 32'h0, 0, 0);
    st(SW, 32'h40, 32'hFFFF_FFFF, 4'd7);
    ld(LW, 32'h40, 32'h0, 4'd5, 0);
    ld(LW, 32'h00, 32'h0102_0304, 0, 0);
    st(SW, 32'h3C, 32'h600D_CAFE, 0);
    ld(LW, 32'h3C, 32'h600D_CAFE, 0, 0);
    ld(LW, 32'h10, 32'hDEAD_BEEF, 0, 5);

    // Flush while a store waits: it must be dropped.
    ex_valid_i = 1; memwrite_i = 1; width_select_i = SW; alu_result_i = 32'h10;
    store_data_i = 32'hA5A5_A5A5;
    @(posedge clk_i);
    #1 idle();
    flush_i = 1;
    @(posedge clk_i);
    #1 flush_i = 0;
    @(negedge clk_i);
    chk("flush_valid", mem_valid_o, 0);
    chk("flush_exc", exc_valid_o, 0);
    @(posedge clk_i);
    #1;
    ld(LW, 32'h10, 32'hDEAD_BEEF, 0, 0);

    // Reset while a load waits.
    ex_valid_i = 1; memread_i = 1; regwrite_i = 1; width_select_i = LW; alu_result_i = 32'h10;
    @(posedge clk_i);
    #1 idle();
    rst_ni = 0;
    @(posedge clk_i);
    #1 rst_ni = 1;
    @(negedge clk_i);
    chk_all_zero("midwait_reset");
    @(posedge clk_i);
    #1;
    ld(LW, 32'h00, 32'h0102_0304, 0, 0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk_i);
    repeat (2) @(posedge clk_i);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
